// File: rtl/command_word_sequencer_pkg.sv
// Shared definitions for the 8259A command-word writer: state encoding
// and the data-bus bit positions that steer ICW/OCW decode.
package pic_command_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } sequencer_state_t;

    localparam int ICW1_SELECT_BIT = 4;
    localparam int OCW3_SELECT_BIT = 3;
    localparam int SNGL_BIT        = 1;
    localparam int IC4_BIT         = 0;

endpackage

// File: rtl/command_word_sequencer_classifier.sv
// Combinational classification of a CPU write by A0, D4 and D3.
// The result is state-independent; the sequencer decides what each class means.
module command_word_classifier (
    input  logic address_0,
    input  logic icw1_select,
    input  logic ocw3_select,
    output logic is_icw1,
    output logic is_a0_high,
    output logic is_ocw2,
    output logic is_ocw3
);

    // A0=0 with D4=1 is always ICW1; A0=0 with D4=0 splits on D3
    always_comb begin
        is_icw1    = ~address_0 & icw1_select;
        is_a0_high = address_0;
        is_ocw2    = ~address_0 & ~icw1_select & ~ocw3_select;
        is_ocw3    = ~address_0 & ~icw1_select & ocw3_select;
    end

endmodule

// File: rtl/command_word_sequencer.sv
// Writer side of the 8259A ICW/OCW register bank. Tracks the
// ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialization sequence and issues
// one-cycle registered write strobes to the command-word registers.
// Optional build macro ICW_SEQUENCE_STATUS_EN exposes the state encoding
// and a saturating count of writes ignored during initialization.
module command_word_sequencer
    import pic_command_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_strobe,
    input  logic                  address_0,
    input  logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_initial_command_word_1,
    output logic                  write_initial_command_word_2,
    output logic                  write_initial_command_word_3,
    output logic                  write_initial_command_word_4,
    output logic                  write_operation_control_word_1,
    output logic                  write_operation_control_word_2,
    output logic                  write_operation_control_word_3,
    output logic                  single_or_cascade_config,
    output logic                  icw4_required,
    output logic                  in_initialization
`ifdef ICW_SEQUENCE_STATUS_EN
    ,
    output logic [1:0]            sequence_state,
    output logic [3:0]            ignored_write_count
`endif
);

    sequencer_state_t state;

    logic is_icw1;
    logic is_a0_high;
    logic is_ocw2;
    logic is_ocw3;

    // Bits that do not take part in command-word decode
    logic unused_data_bits;
    assign unused_data_bits = ^{internal_data_bus[7:5], internal_data_bus[2]};

    command_word_classifier u_classifier (
        .address_0   (address_0),
        .icw1_select (internal_data_bus[ICW1_SELECT_BIT]),
        .ocw3_select (internal_data_bus[OCW3_SELECT_BIT]),
        .is_icw1     (is_icw1),
        .is_a0_high  (is_a0_high),
        .is_ocw2     (is_ocw2),
        .is_ocw3     (is_ocw3)
    );

`ifdef ICW_SEQUENCE_STATUS_EN
    assign sequence_state = state;
`endif

    // Sequencer FSM with registered strobes, latched ICW1 flags and status
    always_ff @(posedge clock) begin
        if (reset) begin
            state                          <= READY;
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
            single_or_cascade_config       <= 1'b0;
            icw4_required                  <= 1'b0;
            in_initialization              <= 1'b0;
`ifdef ICW_SEQUENCE_STATUS_EN
            ignored_write_count            <= 4'd0;
`endif
        end else begin
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
            if (write_strobe) begin
                if (is_icw1) begin
                    // ICW1 restarts the sequence from any state
                    write_initial_command_word_1 <= 1'b1;
                    single_or_cascade_config     <= internal_data_bus[SNGL_BIT];
                    icw4_required                <= internal_data_bus[IC4_BIT];
                    state                        <= WAIT_ICW2;
                    in_initialization            <= 1'b1;
`ifdef ICW_SEQUENCE_STATUS_EN
                    ignored_write_count          <= 4'd0;
`endif
                end else begin
                    case (state)
                        READY: begin
                            if (is_a0_high)
                                write_operation_control_word_1 <= 1'b1;
                            else if (is_ocw2)
                                write_operation_control_word_2 <= 1'b1;
                            else if (is_ocw3)
                                write_operation_control_word_3 <= 1'b1;
                        end
                        WAIT_ICW2: begin
                            if (is_a0_high) begin
                                write_initial_command_word_2 <= 1'b1;
                                if (!single_or_cascade_config) begin
                                    state             <= WAIT_ICW3;
                                    in_initialization <= 1'b1;
                                end else if (icw4_required) begin
                                    state             <= WAIT_ICW4;
                                    in_initialization <= 1'b1;
                                end else begin
                                    state             <= READY;
                                    in_initialization <= 1'b0;
                                end
                            end
                        end
                        WAIT_ICW3: begin
                            if (is_a0_high) begin
                                write_initial_command_word_3 <= 1'b1;
                                if (icw4_required) begin
                                    state             <= WAIT_ICW4;
                                    in_initialization <= 1'b1;
                                end else begin
                                    state             <= READY;
                                    in_initialization <= 1'b0;
                                end
                            end
                        end
                        WAIT_ICW4: begin
                            if (is_a0_high) begin
                                write_initial_command_word_4 <= 1'b1;
                                state                        <= READY;
                                in_initialization            <= 1'b0;
                            end
                        end
                        default: begin
                            state             <= READY;
                            in_initialization <= 1'b0;
                        end
                    endcase
`ifdef ICW_SEQUENCE_STATUS_EN
                    // A0=0/D4=0 during initialization is dropped; count it
                    if (state != READY && !is_a0_high &&
                        ignored_write_count != 4'd15)
                        ignored_write_count <= ignored_write_count + 4'd1;
`endif
                end
            end
        end
    end

endmodule
